// File: rtl/scan_pkg.sv
// Shared types and constants for the keypad/display scan sequencer:
// FSM state encoding, column one-hot codes, key map and small helpers.
package scan_pkg;

   typedef enum logic [1:0] {
      ST_SCAN     = 2'd0,
      ST_DEBOUNCE = 2'd1,
      ST_HELD     = 2'd2,
      ST_RELEASE  = 2'd3
   } scan_state_t;

   // One-hot column drive codes; column 0 is the leftmost bit.
   localparam logic [3:0] COL0 = 4'b1000;
   localparam logic [3:0] COL1 = 4'b0100;
   localparam logic [3:0] COL2 = 4'b0010;
   localparam logic [3:0] COL3 = 4'b0001;

   // Hex code of each key, indexed [column][row bit]; row bit 3 is the top row.
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'hE, 4'h7, 4'h4, 4'h1},
      '{4'h0, 4'h8, 4'h5, 4'h2},
      '{4'hF, 4'h9, 4'h6, 4'h3},
      '{4'hD, 4'hC, 4'hB, 4'hA}
   };

   // Column number of a one-hot column code.
   function automatic logic [1:0] col_index(input logic [3:0] col);
      logic [1:0] idx;
      case (col)
         COL0:    idx = 2'd0;
         COL1:    idx = 2'd1;
         COL2:    idx = 2'd2;
         COL3:    idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Following column in scan order; a corrupted code restarts at column 0.
   function automatic logic [3:0] next_col(input logic [3:0] col);
      logic [3:0] nxt;
      case (col)
         COL0:    nxt = COL1;
         COL1:    nxt = COL2;
         COL2:    nxt = COL3;
         COL3:    nxt = COL0;
         default: nxt = COL0;
      endcase
      return nxt;
   endfunction

   // Highest active row index wins when several rows are active.
   function automatic logic [1:0] priority_row(input logic [3:0] r);
      logic [1:0] idx;
      if (r[3]) begin
         idx = 2'd3;
      end else if (r[2]) begin
         idx = 2'd2;
      end else if (r[1]) begin
         idx = 2'd1;
      end else begin
         idx = 2'd0;
      end
      return idx;
   endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Free-running TIMEBITS-bit counter producing a one-cycle scan strobe
// while the counter sits at all-ones (every 2^TIMEBITS cycles).
module scan_tick_gen #(
   parameter int TIMEBITS = 3
) (
   input  logic clk,
   input  logic reset,
   output logic tick
);

   localparam logic [TIMEBITS-1:0] PRE_LAST = {TIMEBITS{1'b1}} - TIMEBITS'(1);

   logic [TIMEBITS-1:0] cnt_r;
   logic                tick_r;

   // Count cycles and register the strobe one count ahead so it is high exactly at all-ones.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_r + TIMEBITS'(1);
         tick_r <= (cnt_r == PRE_LAST);
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/scan_sequencer.sv
// Keypad scan / debounce controller and two-digit display multiplexer.
// Optional build macro DISP_BLANK_EN inserts a blank phase after each digit
// (01, 00, 10, 00) to suppress ghosting; otherwise digits alternate 01/10.
module scan_sequencer
   import scan_pkg::*;
#(
   parameter int TIMEBITS = 3,
   parameter int DEBOUNCE = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] rows,
   output logic [3:0] col_drive,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic       tick,
   output logic [1:0] disp_en,
   output logic       disp_sel
);

   localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE);
`ifdef DISP_BLANK_EN
   localparam int PHASE_W = 2;
`else
   localparam int PHASE_W = 1;
`endif

   logic               tick_s;
   logic [3:0]         rs_meta_r, rs_r;
   scan_state_t        state_r, state_next_s;
   logic [3:0]         cnt_r, cnt_next_s, cnt_inc_s;
   logic [1:0]         row_r, row_next_s;
   logic [3:0]         col_r, col_next_s;
   logic               key_valid_r, key_valid_next_s;
   logic [3:0]         key_code_r, key_code_next_s;
   logic [PHASE_W-1:0] phase_r, phase_next_s;
   logic [1:0]         disp_en_r, disp_en_next_s;
   logic               disp_sel_r, disp_sel_next_s;
   logic               row_active_s;

   scan_tick_gen #(.TIMEBITS(TIMEBITS)) u_tick_gen (
      .clk   (clk),
      .reset (reset),
      .tick  (tick_s)
   );

   // Two-flop synchronizer for the asynchronous keypad rows.
   always_ff @(posedge clk) begin
      if (reset) begin
         rs_meta_r <= 4'b0000;
         rs_r      <= 4'b0000;
      end else begin
         rs_meta_r <= rows;
         rs_r      <= rs_meta_r;
      end
   end

   assign row_active_s = rs_r[row_r];
   assign cnt_inc_s    = cnt_r + 4'd1;

   // Next-state logic for the scan/debounce FSM; it only moves on tick cycles.
   always_comb begin
      state_next_s     = state_r;
      cnt_next_s       = cnt_r;
      row_next_s       = row_r;
      col_next_s       = col_r;
      key_valid_next_s = 1'b0;
      key_code_next_s  = key_code_r;
      if (tick_s) begin
         case (state_r)
            ST_SCAN: begin
               if (rs_r != 4'b0000) begin
                  state_next_s = ST_DEBOUNCE;
                  row_next_s   = priority_row(rs_r);
                  cnt_next_s   = 4'd1;
               end else begin
                  col_next_s = next_col(col_r);
               end
            end
            ST_DEBOUNCE: begin
               if (row_active_s) begin
                  cnt_next_s = cnt_inc_s;
                  if (cnt_inc_s == DEB_LAST) begin
                     state_next_s     = ST_HELD;
                     key_valid_next_s = 1'b1;
                     key_code_next_s  = KEYMAP[col_index(col_r)][row_r];
                  end else begin
                     state_next_s = ST_DEBOUNCE;
                  end
               end else begin
                  state_next_s = ST_SCAN;
                  cnt_next_s   = 4'd0;
                  col_next_s   = next_col(col_r);
               end
            end
            ST_HELD: begin
               if (!row_active_s) begin
                  state_next_s = ST_RELEASE;
                  cnt_next_s   = 4'd1;
               end else begin
                  state_next_s = ST_HELD;
               end
            end
            ST_RELEASE: begin
               if (!row_active_s) begin
                  cnt_next_s = cnt_inc_s;
                  if (cnt_inc_s == DEB_LAST) begin
                     state_next_s = ST_SCAN;
                     cnt_next_s   = 4'd0;
                     col_next_s   = next_col(col_r);
                  end else begin
                     state_next_s = ST_RELEASE;
                  end
               end else begin
                  state_next_s = ST_HELD;
               end
            end
            default: begin
               state_next_s = ST_SCAN;
               cnt_next_s   = 4'd0;
               col_next_s   = COL0;
            end
         endcase
      end else begin
         state_next_s = state_r;
      end
   end

   // Display phase sequencing; digit enables and decoder select follow the phase.
   always_comb begin
      phase_next_s    = phase_r;
      disp_en_next_s  = disp_en_r;
      disp_sel_next_s = disp_sel_r;
      if (tick_s) begin
         phase_next_s = phase_r + PHASE_W'(1);
`ifdef DISP_BLANK_EN
         case (phase_next_s)
            2'd0: begin
               disp_en_next_s  = 2'b01;
               disp_sel_next_s = 1'b0;
            end
            2'd1: begin
               disp_en_next_s  = 2'b00;
               disp_sel_next_s = disp_sel_r;
            end
            2'd2: begin
               disp_en_next_s  = 2'b10;
               disp_sel_next_s = 1'b1;
            end
            2'd3: begin
               disp_en_next_s  = 2'b00;
               disp_sel_next_s = disp_sel_r;
            end
            default: begin
               disp_en_next_s  = 2'b01;
               disp_sel_next_s = 1'b0;
            end
         endcase
`else
         if (phase_next_s == 1'b0) begin
            disp_en_next_s  = 2'b01;
            disp_sel_next_s = 1'b0;
         end else begin
            disp_en_next_s  = 2'b10;
            disp_sel_next_s = 1'b1;
         end
`endif
      end else begin
         phase_next_s = phase_r;
      end
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_SCAN;
         cnt_r       <= 4'd0;
         row_r       <= 2'd0;
         col_r       <= COL0;
         key_valid_r <= 1'b0;
         key_code_r  <= 4'h0;
         phase_r     <= '0;
         disp_en_r   <= 2'b01;
         disp_sel_r  <= 1'b0;
      end else begin
         state_r     <= state_next_s;
         cnt_r       <= cnt_next_s;
         row_r       <= row_next_s;
         col_r       <= col_next_s;
         key_valid_r <= key_valid_next_s;
         key_code_r  <= key_code_next_s;
         phase_r     <= phase_next_s;
         disp_en_r   <= disp_en_next_s;
         disp_sel_r  <= disp_sel_next_s;
      end
   end

   assign col_drive = col_r;
   assign key_valid = key_valid_r;
   assign key_code  = key_code_r;
   assign tick      = tick_s;
   assign disp_en   = disp_en_r;
   assign disp_sel  = disp_sel_r;

endmodule
